// File: rtl/cpu_mem_bus_arbiter_if.sv
// Purpose: cache-side and memory-side signal bundle of the CPU memory bus arbiter.
// Latency: none, wires only.
// Backpressure: mem_req_ready stalls the memory request; bus_available gates each cache.
//
// Signals:
//   cache side : bus_available, req_read, req_write, req_addr, req_data,
//                resp_valid, resp_addr, resp_data
//   memory side: mem_req_valid/ready/write/addr/data, mem_resp_valid/data
//   status     : protocol_error
// Modports: slave = the arbiter itself; master = caches plus main memory.
interface cpu_mem_bus_if #(
  parameter int LINE_ADDR_WIDTH = 28,
  parameter int LINE_WIDTH      = 128
);
  // cache side
  logic [1:0]                      bus_available;
  logic [1:0]                      req_read;
  logic [1:0]                      req_write;
  logic [1:0][LINE_ADDR_WIDTH-1:0] req_addr;
  logic [1:0][LINE_WIDTH-1:0]      req_data;
  logic [1:0]                      resp_valid;
  logic [LINE_ADDR_WIDTH-1:0]      resp_addr;
  logic [LINE_WIDTH-1:0]           resp_data;
  // memory side
  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic                            mem_req_write;
  logic [LINE_ADDR_WIDTH-1:0]      mem_req_addr;
  logic [LINE_WIDTH-1:0]           mem_req_data;
  logic                            mem_resp_valid;
  logic [LINE_WIDTH-1:0]           mem_resp_data;
  // status
  logic                            protocol_error;

  modport slave (
    input  req_read, req_write, req_addr, req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output bus_available, resp_valid, resp_addr, resp_data,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output protocol_error
  );

  modport master (
    output req_read, req_write, req_addr, req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  bus_available, resp_valid, resp_addr, resp_data,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input  protocol_error
  );
endinterface

// File: rtl/cpu_mem_bus_arbiter.sv
// Purpose: round-robin arbiter between I-cache (port 0) and D-cache (port 1) for one memory bus.
// Latency: read granted at t returns resp_valid at t+3 with zero-wait memory; next grant at t+4.
// Backpressure: mem_req_ready holds ISSUE; one transaction outstanding, grants drop until done.
//
// Ports:
//   clock, reset : system clock, asynchronous active-low reset
//   bus          : cpu_mem_bus_if.slave (cache request/fill channel, memory
//                  request/response channel, sticky protocol_error)
module cpu_mem_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(LINE_WIDTH / 8)
) (
  input  logic         clock,
  input  logic         reset,
  cpu_mem_bus_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                     state_q,     state_d;
  logic                       rr_ptr_q,    rr_ptr_d;
  logic                       owner_q,     owner_d;
  logic [1:0]                 grant_q,     grant_d;
  logic                       cap_write_q, cap_write_d;
  logic [LINE_ADDR_WIDTH-1:0] cap_addr_q,  cap_addr_d;
  logic [LINE_WIDTH-1:0]      cap_data_q,  cap_data_d;
  logic [LINE_WIDTH-1:0]      fill_data_q, fill_data_d;
  logic                       perr_q,      perr_d;

  logic                       sel_read;
  logic                       sel_write;

  function automatic logic [1:0] onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // Request lines of whichever port the pointer currently favours.
  assign sel_read  = bus.req_read[rr_ptr_q];
  assign sel_write = bus.req_write[rr_ptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      grant_q     <= 2'b00;
      cap_write_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_data_q  <= '0;
      fill_data_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      cap_write_q <= cap_write_d;
      cap_addr_q  <= cap_addr_d;
      cap_data_q  <= cap_data_d;
      fill_data_q <= fill_data_d;
      perr_q      <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    cap_write_d = cap_write_q;
    cap_addr_d  = cap_addr_q;
    cap_data_d  = cap_data_q;
    fill_data_d = fill_data_q;
    perr_d      = perr_q;

    case (state_q)
      IDLE: begin
        if (grant_q == 2'b00) begin
          // First cycle out of reset: grant is a register, so publish it
          // before any request can be sampled against it.
          grant_d = onehot(rr_ptr_q);
        end else if (sel_read || sel_write) begin
          cap_write_d = !sel_read;  // read wins when both are raised
          cap_addr_d  = bus.req_addr[rr_ptr_q];
          cap_data_d  = bus.req_data[rr_ptr_q];
          owner_d     = rr_ptr_q;
          grant_d     = 2'b00;
          state_d     = ISSUE;
          if (sel_read && sel_write) begin
            perr_d = 1'b1;
          end
        end else begin
          // Granted port is idle: hand the grant over next cycle.
          rr_ptr_d = ~rr_ptr_q;
          grant_d  = onehot(~rr_ptr_q);
        end
      end

      ISSUE: begin
        if (bus.mem_req_ready) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (bus.mem_resp_valid) begin
          if (!cap_write_q) begin
            fill_data_d = bus.mem_resp_data;
            state_d     = RESPOND;
          end else begin
            // Write acknowledge closes the write-back.
            rr_ptr_d = ~rr_ptr_q;
            grant_d  = onehot(~rr_ptr_q);
            state_d  = IDLE;
          end
        end
      end

      RESPOND: begin
        rr_ptr_d = ~rr_ptr_q;
        grant_d  = onehot(~rr_ptr_q);
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Memory may only answer while a transaction waits for it.
    if (bus.mem_resp_valid && (state_q != WAIT)) begin
      perr_d = 1'b1;
    end
  end

  // Every output comes straight from registers (gated by decoded state).
  assign bus.bus_available  = grant_q;

  assign bus.mem_req_valid  = (state_q == ISSUE);
  assign bus.mem_req_write  = (state_q == ISSUE) ? cap_write_q : 1'b0;
  assign bus.mem_req_addr   = (state_q == ISSUE) ? cap_addr_q  : '0;
  assign bus.mem_req_data   = (state_q == ISSUE) ? cap_data_q  : '0;

  assign bus.resp_valid     = (state_q == RESPOND) ? onehot(owner_q) : 2'b00;
  assign bus.resp_addr      = (state_q == RESPOND) ? cap_addr_q  : '0;
  assign bus.resp_data      = (state_q == RESPOND) ? fill_data_q : '0;

  assign bus.protocol_error = perr_q;

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// Purpose: scoreboard bench for cpu_mem_bus_arbiter: directed scenarios plus randomized traffic.
// Latency: expected fill timing checked directly in the directed read scenario.
// Backpressure: memory model stalls mem_req_ready and delays responses at random.
module tb_cpu_mem_bus_arbiter;
  localparam int LAW = 28;
  localparam int LW  = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cpu_mem_bus_if #(.LINE_ADDR_WIDTH(LAW), .LINE_WIDTH(LW)) bus ();

  cpu_mem_bus_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { bit w; bit both; logic [LAW-1:0] a; logic [LW-1:0] d; } txn_t;
  typedef struct { bit w; logic [LAW-1:0] a; logic [LW-1:0] d; } mreq_t;
  typedef struct { logic [1:0] port; logic [LAW-1:0] a; logic [LW-1:0] d; } resp_t;

  txn_t  pq0[$];
  txn_t  pq1[$];
  mreq_t exp_mem_q[$];
  resp_t exp_resp_q[$];
  logic [LW-1:0] env_mem [logic [LAW-1:0]];
  logic [LW-1:0] ref_mem [logic [LAW-1:0]];

  int n_chk = 0;
  int n_fail = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit resp_en = 1'b1;
  bit rand_delay = 1'b0;
  int inject_req = 0;

  function automatic logic [LW-1:0] hashf(input logic [LAW-1:0] a);
    return {a, 4'h5, ~a, 4'hA, a ^ 28'h5A5A5A5, 4'h3, 4'h0, a};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache driver: presents the head of each port queue; pops it once the
  // port was granted while requesting.
  initial begin : driver
    bit acc0, acc1;
    bus.req_read  = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clock);
      acc0 = bus.bus_available[0] && (bus.req_read[0] || bus.req_write[0]);
      acc1 = bus.bus_available[1] && (bus.req_read[1] || bus.req_write[1]);
      @(posedge clock);
      #1;
      if (acc0 && pq0.size() > 0) void'(pq0.pop_front());
      if (acc1 && pq1.size() > 0) void'(pq1.pop_front());
      if (pq0.size() > 0) begin
        bus.req_read[0]  = !pq0[0].w || pq0[0].both;
        bus.req_write[0] = pq0[0].w || pq0[0].both;
        bus.req_addr[0]  = pq0[0].a;
        bus.req_data[0]  = pq0[0].d;
      end else begin
        bus.req_read[0]  = 1'b0;
        bus.req_write[0] = 1'b0;
      end
      if (pq1.size() > 0) begin
        bus.req_read[1]  = !pq1[0].w || pq1[0].both;
        bus.req_write[1] = pq1[0].w || pq1[0].both;
        bus.req_addr[1]  = pq1[0].a;
        bus.req_data[1]  = pq1[0].d;
      end else begin
        bus.req_read[1]  = 1'b0;
        bus.req_write[1] = 1'b0;
      end
    end
  end

  // Main memory model.
  initial begin : mem_env
    bit hs, hw, pend;
    logic [LAW-1:0] ha;
    logic [LW-1:0] hd, rdata;
    int dly, inj_seen;
    pend = 1'b0; dly = 0; inj_seen = 0; rdata = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clock);
      hs = bus.mem_req_valid && bus.mem_req_ready;
      hw = bus.mem_req_write;
      ha = bus.mem_req_addr;
      hd = bus.mem_req_data;
      @(posedge clock);
      #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      if (hs) begin
        if (hw) env_mem[ha] = hd;
        rdata = hw ? '0 : (env_mem.exists(ha) ? env_mem[ha] : hashf(ha));
        pend  = resp_en;
        dly   = rand_delay ? int'($urandom_range(0, 3)) : 0;
      end
      if (pend) begin
        if (dly == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = rdata;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end
      if (inject_req != inj_seen) begin
        inj_seen = inject_req;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {4{32'h5BAD_F00D}};
      end
      case (ready_mode)
        0:       bus.mem_req_ready = 1'b1;
        1:       bus.mem_req_ready = ($urandom_range(0, 2) != 0);
        default: bus.mem_req_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    mreq_t em;
    resp_t er;
    forever begin
      @(negedge clock);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        chk("mem_req_expected", 128'(exp_mem_q.size() != 0), 128'(1));
        if (exp_mem_q.size() != 0) begin
          em = exp_mem_q.pop_front();
          chk("mem_req_write", 128'(bus.mem_req_write), 128'(em.w));
          chk("mem_req_addr", 128'(bus.mem_req_addr), 128'(em.a));
          if (em.w) chk("mem_req_data", bus.mem_req_data, em.d);
        end
      end
      if (bus.resp_valid != 2'b00) begin
        chk("resp_expected", 128'(exp_resp_q.size() != 0), 128'(1));
        if (exp_resp_q.size() != 0) begin
          er = exp_resp_q.pop_front();
          chk("resp_port", 128'(bus.resp_valid), 128'(er.port));
          chk("resp_addr", 128'(bus.resp_addr), 128'(er.a));
          chk("resp_data", bus.resp_data, er.d);
        end
      end else begin
        chk("resp_addr_idle_zero", 128'(bus.resp_addr), 128'(0));
        chk("resp_data_idle_zero", bus.resp_data, 128'(0));
      end
      chk("grant_not_both", 128'(bus.bus_available == 2'b11), 128'(0));
    end
  end

  // Transaction-level reference: after reset port 0 is favoured; every
  // completed transaction hands priority to the other port; a port with no
  // pending work is skipped.
  task automatic run_model();
    txn_t q0[$];
    txn_t q1[$];
    txn_t t;
    mreq_t m;
    resp_t r;
    int last, p;
    q0 = pq0;
    q1 = pq1;
    last = 1;
    while (q0.size() + q1.size() > 0) begin
      p = 1 - last;
      if (p == 0 && q0.size() == 0) p = 1;
      else if (p == 1 && q1.size() == 0) p = 0;
      if (p == 0) t = q0.pop_front();
      else        t = q1.pop_front();
      last = p;
      m.w = t.w && !t.both;
      m.a = t.a;
      m.d = t.d;
      exp_mem_q.push_back(m);
      if (m.w) begin
        ref_mem[t.a] = t.d;
      end else begin
        r.port = (p == 0) ? 2'b01 : 2'b10;
        r.a    = t.a;
        r.d    = ref_mem.exists(t.a) ? ref_mem[t.a] : hashf(t.a);
        exp_resp_q.push_back(r);
      end
    end
  endtask

  task automatic reset_on();
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("rst_bus_available", 128'(bus.bus_available), 128'(0));
    chk("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
    chk("rst_resp_addr", 128'(bus.resp_addr), 128'(0));
    chk("rst_resp_data", bus.resp_data, 128'(0));
    chk("rst_mem_req_valid", 128'(bus.mem_req_valid), 128'(0));
    chk("rst_mem_req_write", 128'(bus.mem_req_write), 128'(0));
    chk("rst_mem_req_addr", 128'(bus.mem_req_addr), 128'(0));
    chk("rst_mem_req_data", bus.mem_req_data, 128'(0));
    chk("rst_protocol_error", 128'(bus.protocol_error), 128'(0));
  endtask

  task automatic reset_off();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
      done = (pq0.size() + pq1.size() + exp_mem_q.size() + exp_resp_q.size()) == 0;
    end
    chk("drain_in_budget", 128'(done), 128'(1));
  endtask

  task automatic push_txn(input int port, input bit w, input bit both,
                          input logic [LAW-1:0] a, input logic [LW-1:0] d);
    txn_t t;
    t.w = w; t.both = both; t.a = a; t.d = d;
    if (port == 0) pq0.push_back(t);
    else           pq1.push_back(t);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    mreq_t m;
    resp_t r;
    int cnt;
    int n0, n1;

    // Reset state.
    reset_on();
    reset_off();

    // Single read on port 1 with zero-wait memory.
    env_mem[28'h0000_123] = 128'hDEAD_BEEF;
    cnt = 0;
    while (bus.bus_available != 2'b01 && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    chk("rd_pre_grant_port0", 128'(bus.bus_available), 128'(2'b01));
    push_txn(1, 1'b0, 1'b0, 28'h0000_123, '0);
    m.w = 1'b0; m.a = 28'h0000_123; m.d = '0;
    exp_mem_q.push_back(m);
    r.port = 2'b10; r.a = 28'h0000_123; r.d = 128'hDEAD_BEEF;
    exp_resp_q.push_back(r);
    @(negedge clock);  // grant cycle t
    chk("rd_grant_port1", 128'(bus.bus_available), 128'(2'b10));
    @(negedge clock);  // t+1
    chk("rd_mem_req_valid", 128'(bus.mem_req_valid), 128'(1));
    chk("rd_mem_req_write", 128'(bus.mem_req_write), 128'(0));
    chk("rd_mem_req_addr", 128'(bus.mem_req_addr), 128'(28'h0000_123));
    @(negedge clock);  // t+2
    chk("rd_no_early_resp", 128'(bus.resp_valid), 128'(0));
    @(negedge clock);  // t+3
    chk("rd_resp_valid_t3", 128'(bus.resp_valid), 128'(2'b10));
    chk("rd_resp_addr_t3", 128'(bus.resp_addr), 128'(28'h0000_123));
    chk("rd_resp_data_t3", bus.resp_data, 128'hDEAD_BEEF);
    @(negedge clock);  // t+4
    chk("rd_next_grant_port0", 128'(bus.bus_available), 128'(2'b01));

    // Write-back on port 0 with ready held low for 5 cycles.
    ready_mode = 2;
    push_txn(0, 1'b1, 1'b0, 28'h0000_040, 128'h0123_4567_89AB_CDEF);
    m.w = 1'b1; m.a = 28'h0000_040; m.d = 128'h0123_4567_89AB_CDEF;
    exp_mem_q.push_back(m);
    cnt = 0;
    while (!bus.mem_req_valid && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    cnt = 0;
    while (bus.mem_req_valid && cnt < 20) begin
      cnt++;
      chk("wb_addr_stable", 128'(bus.mem_req_addr), 128'(28'h0000_040));
      chk("wb_data_stable", bus.mem_req_data, 128'h0123_4567_89AB_CDEF);
      if (cnt == 5) ready_mode = 0;
      @(negedge clock);
    end
    chk("wb_valid_cycles", 128'(cnt), 128'(6));
    @(negedge clock);
    chk("wb_grant_after_ack", 128'(bus.bus_available), 128'(2'b10));

    // Read and write together on the granted port: read wins, error flagged.
    push_txn(0, 1'b0, 1'b1, 28'h0000_200, '0);
    m.w = 1'b0; m.a = 28'h0000_200; m.d = '0;
    exp_mem_q.push_back(m);
    r.port = 2'b01; r.a = 28'h0000_200; r.d = hashf(28'h0000_200);
    exp_resp_q.push_back(r);
    wait_done(100);
    chk("both_rw_protocol_error", 128'(bus.protocol_error), 128'(1));

    // Idle skip: only port 1 requests, pointer at 0 after reset.
    reset_on();
    push_txn(1, 1'b0, 1'b0, 28'h0000_250, '0);
    m.w = 1'b0; m.a = 28'h0000_250; m.d = '0;
    exp_mem_q.push_back(m);
    r.port = 2'b10; r.a = 28'h0000_250; r.d = hashf(28'h0000_250);
    exp_resp_q.push_back(r);
    reset_off();
    cnt = 0;
    while (bus.bus_available == 2'b00 && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    chk("skip_first_grant", 128'(bus.bus_available), 128'(2'b01));
    @(negedge clock);
    chk("skip_second_grant", 128'(bus.bus_available), 128'(2'b10));
    wait_done(100);

    // Spurious memory response while idle.
    chk("spur_perr_before", 128'(bus.protocol_error), 128'(0));
    inject_req++;
    repeat (2) @(negedge clock);
    chk("spur_perr_after", 128'(bus.protocol_error), 128'(1));
    chk("spur_no_resp", 128'(bus.resp_valid), 128'(0));
    chk("spur_still_idle", 128'(bus.bus_available != 2'b00), 128'(1));

    // Reset in the middle of WAIT, then a late response.
    resp_en = 1'b0;
    push_txn(0, 1'b0, 1'b0, 28'h0000_300, '0);
    m.w = 1'b0; m.a = 28'h0000_300; m.d = '0;
    exp_mem_q.push_back(m);
    cnt = 0;
    while (exp_mem_q.size() != 0 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    repeat (2) @(negedge clock);
    chk("wait_no_grant", 128'(bus.bus_available), 128'(0));
    chk("wait_no_req", 128'(bus.mem_req_valid), 128'(0));
    reset_on();
    reset_off();
    inject_req++;
    resp_en = 1'b1;
    repeat (3) @(negedge clock);
    chk("late_resp_perr", 128'(bus.protocol_error), 128'(1));
    chk("late_resp_no_fill", 128'(bus.resp_valid), 128'(0));

    // Contention: both ports stream reads, strict 0,1,0,1 interleave.
    reset_on();
    ready_mode = 0;
    rand_delay = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_txn(0, 1'b0, 1'b0, 28'h010_0000 + LAW'($urandom_range(0, 255)), '0);
      push_txn(1, 1'b0, 1'b0, 28'h020_0000 + LAW'($urandom_range(0, 255)), '0);
    end
    run_model();
    reset_off();
    wait_done(400);

    // Randomized mixed traffic with random stalls and response delays.
    for (int it = 0; it < 4; it++) begin
      reset_on();
      ready_mode = 1;
      rand_delay = 1'b1;
      n0 = int'($urandom_range(0, 8));
      n1 = int'($urandom_range(1, 8));
      for (int i = 0; i < n0; i++)
        push_txn(0, 1'($urandom_range(0, 1)), 1'b0, 28'h000_0800 + LAW'($urandom_range(0, 7)),
                 {$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < n1; i++)
        push_txn(1, 1'($urandom_range(0, 1)), 1'b0, 28'h000_0800 + LAW'($urandom_range(0, 7)),
                 {$urandom, $urandom, $urandom, $urandom});
      run_model();
      reset_off();
      wait_done(2000);
    end

    repeat (5) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
